// File: rtl/cnt_checker_if.sv
// Bundles the sampled count, control strobes and status readout of cnt_checker.
// master = the side driving cnt_i/en_i/clr_i; slave = the checker itself.
interface cnt_checker_if #(
   parameter int WIDTH  = 8,
   parameter int ERR_W  = 8,
   parameter int WRAP_W = 16
);
   logic [WIDTH-1:0]  cnt_i;
   logic              en_i;
   logic              clr_i;
   logic              locked_o;
   logic              err_o;
   logic              err_sticky_o;
   logic [ERR_W-1:0]  err_cnt_o;
   logic [WRAP_W-1:0] wrap_cnt_o;
   logic [WIDTH-1:0]  exp_o;
   logic [WIDTH-1:0]  got_o;

   modport master (
      output cnt_i, en_i, clr_i,
      input  locked_o, err_o, err_sticky_o, err_cnt_o, wrap_cnt_o, exp_o, got_o
   );

   modport slave (
      input  cnt_i, en_i, clr_i,
      output locked_o, err_o, err_sticky_o, err_cnt_o, wrap_cnt_o, exp_o, got_o
   );
endinterface

// File: rtl/cnt_checker.sv
// Locks onto a +1 counter sequence and flags skipped/repeated/corrupt samples.
// Optional CNT_CHECK_CAPTURE_EN keeps expected/received values of the first error.
//
// state | meaning
// IDLE  | checking disabled; waits for en_i to take a first sample
// SYNC  | counting consecutive +1 steps towards lock; mismatches silently resync
// TRACK | locked; mismatches raise err_o and fall back to SYNC
module cnt_checker #(
   parameter int WIDTH    = 8,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8,
   parameter int WRAP_W   = 16
) (
   input logic        clk,
   input logic        reset,
   cnt_checker_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SYNC  = 2'd1,
      S_TRACK = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  prev_q, prev_d;
   logic [3:0]        lock_ctr_q, lock_ctr_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic              sticky_q, sticky_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

   logic [WIDTH-1:0]  exp_val;
   logic              match;
   logic              track_err;
   logic              track_wrap;
   logic [ERR_W-1:0]  err_base;
   logic [WRAP_W-1:0] wrap_base;

   assign exp_val    = prev_q + WIDTH'(1);
   assign match      = (bus.cnt_i == exp_val);
   assign track_err  = bus.en_i && (state_q == S_TRACK) && !match;
   assign track_wrap = bus.en_i && (state_q == S_TRACK) && match && (prev_q == '1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!bus.en_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_SYNC;
            S_SYNC:  if (match && (lock_ctr_q == LOCK_LAST)) state_d = S_TRACK;
            S_TRACK: if (!match) state_d = S_SYNC;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      prev_d     = bus.en_i ? bus.cnt_i : prev_q;
      lock_ctr_d = 4'd0;
      if (bus.en_i) begin
         case (state_q)
            S_SYNC:  lock_ctr_d = match ? lock_ctr_q + 4'd1 : 4'd0;
            S_TRACK: lock_ctr_d = match ? lock_ctr_q : 4'd0;
            default: lock_ctr_d = 4'd0;
         endcase
      end
      locked_d = (state_d == S_TRACK);
      err_d    = track_err;

      // clr_i wipes the old totals first so a coincident event still counts once
      sticky_d   = (bus.clr_i ? 1'b0 : sticky_q) | track_err;
      err_base   = bus.clr_i ? '0 : err_cnt_q;
      wrap_base  = bus.clr_i ? '0 : wrap_cnt_q;
      err_cnt_d  = (track_err && (err_base != '1)) ? err_base + ERR_W'(1) : err_base;
      wrap_cnt_d = (track_wrap && (wrap_base != '1)) ? wrap_base + WRAP_W'(1) : wrap_base;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q     <= '0;
         lock_ctr_q <= '0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         sticky_q   <= 1'b0;
         err_cnt_q  <= '0;
         wrap_cnt_q <= '0;
      end else begin
         prev_q     <= prev_d;
         lock_ctr_q <= lock_ctr_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
         sticky_q   <= sticky_d;
         err_cnt_q  <= err_cnt_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   assign bus.locked_o     = locked_q;
   assign bus.err_o        = err_q;
   assign bus.err_sticky_o = sticky_q;
   assign bus.err_cnt_o    = err_cnt_q;
   assign bus.wrap_cnt_o   = wrap_cnt_q;

`ifdef CNT_CHECK_CAPTURE_EN
   logic             capt_q, capt_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] got_q, got_d;

   always_comb begin
      capt_d = bus.clr_i ? 1'b0 : capt_q;
      exp_d  = bus.clr_i ? '0 : exp_q;
      got_d  = bus.clr_i ? '0 : got_q;
      if (track_err && !capt_d) begin
         capt_d = 1'b1;
         exp_d  = exp_val;
         got_d  = bus.cnt_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         capt_q <= 1'b0;
         exp_q  <= '0;
         got_q  <= '0;
      end else begin
         capt_q <= capt_d;
         exp_q  <= exp_d;
         got_q  <= got_d;
      end
   end

   assign bus.exp_o = exp_q;
   assign bus.got_o = got_q;
`else
   assign bus.exp_o = '0;
   assign bus.got_o = '0;
`endif

endmodule

// File: tb/tb_cnt_checker.sv
// Directed bench for cnt_checker: lock, wrap, error, saturation, clear, enable drop, reset, repeat.
module tb_cnt_checker;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cnt_checker_if bus_if ();

   cnt_checker u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int         n_pass = 0;
   int         n_total = 0;
   logic [7:0] prev_v = 8'd0;
   bit         err_seen = 1'b0;

   task automatic step(input logic [7:0] v);
      bus_if.cnt_i = v;
      @(posedge clk);
      #1;
      if (bus_if.err_o === 1'b1) err_seen = 1'b1;
      prev_v = v;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_if.en_i = 1'b0;
      bus_if.clr_i = 1'b0;
      step(8'd0);
      step(8'd0);
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL rst_locked: got %0b want 0", bus_if.locked_o); else n_pass++;
      n_total++; if (bus_if.err_o !== 1'b0) $display("FAIL rst_err: got %0b want 0", bus_if.err_o); else n_pass++;
      n_total++; if (bus_if.err_sticky_o !== 1'b0) $display("FAIL rst_sticky: got %0b want 0", bus_if.err_sticky_o); else n_pass++;
      n_total++; if (bus_if.err_cnt_o !== 8'd0) $display("FAIL rst_err_cnt: got %0d want 0", bus_if.err_cnt_o); else n_pass++;
      n_total++; if (bus_if.wrap_cnt_o !== 16'd0) $display("FAIL rst_wrap_cnt: got %0d want 0", bus_if.wrap_cnt_o); else n_pass++;
      n_total++; if (bus_if.exp_o !== 8'd0) $display("FAIL rst_exp: got %0d want 0", bus_if.exp_o); else n_pass++;
      n_total++; if (bus_if.got_o !== 8'd0) $display("FAIL rst_got: got %0d want 0", bus_if.got_o); else n_pass++;
   endtask

   task automatic test_lock();
      reset = 1'b0;
      bus_if.en_i = 1'b1;
      err_seen = 1'b0;
      for (int i = 0; i <= 3; i++) step(8'(i));
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL lock_early: got %0b want 0", bus_if.locked_o); else n_pass++;
      step(8'd4);
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL lock_at_4: got %0b want 1", bus_if.locked_o); else n_pass++;
      for (int i = 5; i <= 10; i++) step(8'(i));
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL lock_hold: got %0b want 1", bus_if.locked_o); else n_pass++;
      n_total++; if (err_seen !== 1'b0) $display("FAIL lock_no_err: got %0b want 0", err_seen); else n_pass++;
   endtask

   task automatic test_wrap();
      err_seen = 1'b0;
      for (int i = 11; i <= 255; i++) step(8'(i));
      n_total++; if (bus_if.wrap_cnt_o !== 16'd0) $display("FAIL wrap_before: got %0d want 0", bus_if.wrap_cnt_o); else n_pass++;
      step(8'd0);
      step(8'd1);
      n_total++; if (bus_if.wrap_cnt_o !== 16'd1) $display("FAIL wrap_cnt: got %0d want 1", bus_if.wrap_cnt_o); else n_pass++;
      n_total++; if (err_seen !== 1'b0) $display("FAIL wrap_no_err: got %0b want 0", err_seen); else n_pass++;
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL wrap_locked: got %0b want 1", bus_if.locked_o); else n_pass++;
   endtask

   task automatic test_mismatch();
      for (int i = 2; i <= 10; i++) step(8'(i));
      step(8'd12);
      n_total++; if (bus_if.err_o !== 1'b1) $display("FAIL mis_err: got %0b want 1", bus_if.err_o); else n_pass++;
      n_total++; if (bus_if.err_cnt_o !== 8'd1) $display("FAIL mis_err_cnt: got %0d want 1", bus_if.err_cnt_o); else n_pass++;
      n_total++; if (bus_if.err_sticky_o !== 1'b1) $display("FAIL mis_sticky: got %0b want 1", bus_if.err_sticky_o); else n_pass++;
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL mis_unlock: got %0b want 0", bus_if.locked_o); else n_pass++;
`ifdef CNT_CHECK_CAPTURE_EN
      n_total++; if (bus_if.exp_o !== 8'd11) $display("FAIL mis_exp: got %0d want 11", bus_if.exp_o); else n_pass++;
      n_total++; if (bus_if.got_o !== 8'd12) $display("FAIL mis_got: got %0d want 12", bus_if.got_o); else n_pass++;
`else
      n_total++; if (bus_if.exp_o !== 8'd0) $display("FAIL mis_exp: got %0d want 0", bus_if.exp_o); else n_pass++;
      n_total++; if (bus_if.got_o !== 8'd0) $display("FAIL mis_got: got %0d want 0", bus_if.got_o); else n_pass++;
`endif
      step(8'd13);
      n_total++; if (bus_if.err_o !== 1'b0) $display("FAIL mis_pulse: got %0b want 0", bus_if.err_o); else n_pass++;
      step(8'd14);
      step(8'd15);
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL relock_early: got %0b want 0", bus_if.locked_o); else n_pass++;
      step(8'd16);
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL relock: got %0b want 1", bus_if.locked_o); else n_pass++;
      step(8'd17);
      n_total++; if (bus_if.err_sticky_o !== 1'b1) $display("FAIL sticky_hold: got %0b want 1", bus_if.err_sticky_o); else n_pass++;
   endtask

   task automatic test_saturation();
      logic [7:0] e_v, g_v;
      logic [15:0] exp_wrap;
      for (int k = 0; k < 300; k++) begin
         step(prev_v + 8'd2);
         for (int j = 0; j < 4; j++) step(prev_v + 8'd1);
      end
      n_total++; if (bus_if.err_cnt_o !== 8'd255) $display("FAIL sat_err_cnt: got %0d want 255", bus_if.err_cnt_o); else n_pass++;
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL sat_locked: got %0b want 1", bus_if.locked_o); else n_pass++;
      step(prev_v + 8'd2);
      n_total++; if (bus_if.err_cnt_o !== 8'd255) $display("FAIL sat_hold: got %0d want 255", bus_if.err_cnt_o); else n_pass++;
`ifdef CNT_CHECK_CAPTURE_EN
      n_total++; if (bus_if.exp_o !== 8'd11) $display("FAIL sat_exp_held: got %0d want 11", bus_if.exp_o); else n_pass++;
`endif
      for (int j = 0; j < 4; j++) step(prev_v + 8'd1);
      exp_wrap = (prev_v == 8'hFF) ? 16'd1 : 16'd0;
      bus_if.clr_i = 1'b1;
      step(prev_v + 8'd1);
      bus_if.clr_i = 1'b0;
      n_total++; if (bus_if.err_cnt_o !== 8'd0) $display("FAIL clr_err_cnt: got %0d want 0", bus_if.err_cnt_o); else n_pass++;
      n_total++; if (bus_if.err_sticky_o !== 1'b0) $display("FAIL clr_sticky: got %0b want 0", bus_if.err_sticky_o); else n_pass++;
      n_total++; if (bus_if.wrap_cnt_o !== exp_wrap) $display("FAIL clr_wrap_cnt: got %0d want %0d", bus_if.wrap_cnt_o, exp_wrap); else n_pass++;
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL clr_keeps_lock: got %0b want 1", bus_if.locked_o); else n_pass++;
      e_v = prev_v + 8'd1;
      g_v = prev_v + 8'd3;
      bus_if.clr_i = 1'b1;
      step(g_v);
      bus_if.clr_i = 1'b0;
      n_total++; if (bus_if.err_cnt_o !== 8'd1) $display("FAIL clr_err_same: got %0d want 1", bus_if.err_cnt_o); else n_pass++;
      n_total++; if (bus_if.err_sticky_o !== 1'b1) $display("FAIL clr_sticky_same: got %0b want 1", bus_if.err_sticky_o); else n_pass++;
      n_total++; if (bus_if.err_o !== 1'b1) $display("FAIL clr_err_pulse: got %0b want 1", bus_if.err_o); else n_pass++;
`ifdef CNT_CHECK_CAPTURE_EN
      n_total++; if (bus_if.exp_o !== e_v) $display("FAIL clr_exp: got %0d want %0d", bus_if.exp_o, e_v); else n_pass++;
      n_total++; if (bus_if.got_o !== g_v) $display("FAIL clr_got: got %0d want %0d", bus_if.got_o, g_v); else n_pass++;
`endif
   endtask

   task automatic test_en_drop();
      for (int j = 0; j < 4; j++) step(prev_v + 8'd1);
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL en_pre_lock: got %0b want 1", bus_if.locked_o); else n_pass++;
      err_seen = 1'b0;
      bus_if.en_i = 1'b0;
      step(8'd99);
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL en_drop_unlock: got %0b want 0", bus_if.locked_o); else n_pass++;
      bus_if.en_i = 1'b1;
      for (int i = 50; i <= 53; i++) step(8'(i));
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL en_resync_early: got %0b want 0", bus_if.locked_o); else n_pass++;
      step(8'd54);
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL en_relock: got %0b want 1", bus_if.locked_o); else n_pass++;
      n_total++; if (err_seen !== 1'b0) $display("FAIL en_no_err: got %0b want 0", err_seen); else n_pass++;
      reset = 1'b1;
      step(8'd200);
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL rst_mid_locked: got %0b want 0", bus_if.locked_o); else n_pass++;
      n_total++; if (bus_if.err_o !== 1'b0) $display("FAIL rst_mid_err: got %0b want 0", bus_if.err_o); else n_pass++;
      n_total++; if (bus_if.err_cnt_o !== 8'd0) $display("FAIL rst_mid_err_cnt: got %0d want 0", bus_if.err_cnt_o); else n_pass++;
      n_total++; if (bus_if.err_sticky_o !== 1'b0) $display("FAIL rst_mid_sticky: got %0b want 0", bus_if.err_sticky_o); else n_pass++;
      n_total++; if (bus_if.exp_o !== 8'd0) $display("FAIL rst_mid_exp: got %0d want 0", bus_if.exp_o); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_repeat();
      err_seen = 1'b0;
      step(8'd5);
      step(8'd6);
      step(8'd7);
      step(8'd7);
      step(8'd8);
      step(8'd9);
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL rep_restart: got %0b want 0", bus_if.locked_o); else n_pass++;
      step(8'd10);
      n_total++; if (bus_if.locked_o !== 1'b0) $display("FAIL rep_early: got %0b want 0", bus_if.locked_o); else n_pass++;
      step(8'd11);
      n_total++; if (bus_if.locked_o !== 1'b1) $display("FAIL rep_lock: got %0b want 1", bus_if.locked_o); else n_pass++;
      n_total++; if (err_seen !== 1'b0) $display("FAIL rep_no_err: got %0b want 0", err_seen); else n_pass++;
   endtask

   initial begin
      bus_if.cnt_i = 8'd0;
      bus_if.en_i  = 1'b0;
      bus_if.clr_i = 1'b0;
      test_reset();
      test_lock();
      test_wrap();
      test_mismatch();
      test_saturation();
      test_en_drop();
      test_repeat();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
